// File: rtl/voq_output_scheduler.sv
// Per-output-port VOQ read scheduler: round-robin / weighted round-robin source
// selection, grant held for a whole packet, watchdog abort on a missing eop.

module voq_src_lane #(
  parameter int WEIGHT_W = 4
) (
  input  logic [WEIGHT_W-1:0] weight,
  output logic [WEIGHT_W-1:0] eff_weight
);
  // A programmed weight of 0 still earns one packet per turn.
  assign eff_weight = (weight == '0) ? WEIGHT_W'(1) : weight;
endmodule

module voq_output_scheduler #(
  parameter int PORT_NUB_TOTAL = 16,
  parameter int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
  parameter int WEIGHT_W       = 4,
  parameter int TIMEOUT_CYC    = 1024
) (
  input  logic                               internal_clk,
  input  logic                               rst,
  input  logic [PORT_NUB_TOTAL-1:0]          empty_in,
  input  logic                               ready_in,
  input  logic                               qos_mode,
  input  logic [PORT_NUB_TOTAL*WEIGHT_W-1:0] wrr_weight,
  input  logic                               rd_done,
  output logic [WIDTH_SEL-1:0]               rd_sel,
  output logic                               rd_en,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, ARB, READ, DONE} state_t;

  state_t                                 state, state_nxt;
  logic [WIDTH_SEL-1:0]                   ptr, ptr_nxt, sel_nxt;
  logic [WEIGHT_W-1:0]                    credit, credit_nxt;
  logic [WDOG_W-1:0]                      wdog, wdog_nxt;
  logic                                   tmo_nxt;
  logic [PORT_NUB_TOTAL-1:0][WEIGHT_W-1:0] eff_w;
  logic                                   found;
  logic [WIDTH_SEL-1:0]                   found_idx;
  logic [WIDTH_SEL:0]                     idx;

  for (genvar s = 0; s < PORT_NUB_TOTAL; s++) begin : g_lane
    voq_src_lane #(.WEIGHT_W(WEIGHT_W)) u_lane (
      .weight     (wrr_weight[s*WEIGHT_W +: WEIGHT_W]),
      .eff_weight (eff_w[s])
    );
  end

  function automatic logic [WIDTH_SEL-1:0] inc_mod(input logic [WIDTH_SEL-1:0] v);
    return (v == WIDTH_SEL'(PORT_NUB_TOTAL-1)) ? '0 : v + 1'b1;
  endfunction

  // First non-empty source at or after ptr, wrapping at PORT_NUB_TOTAL (not 2^WIDTH_SEL).
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    idx       = '0;
    for (int i = 0; i < PORT_NUB_TOTAL; i++) begin
      idx = {1'b0, ptr} + (WIDTH_SEL+1)'(i);
      if (idx >= (WIDTH_SEL+1)'(PORT_NUB_TOTAL)) idx = idx - (WIDTH_SEL+1)'(PORT_NUB_TOTAL);
      if (!found && !empty_in[idx[WIDTH_SEL-1:0]]) begin
        found     = 1'b1;
        found_idx = idx[WIDTH_SEL-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    sel_nxt    = rd_sel;
    credit_nxt = credit;
    wdog_nxt   = wdog;
    tmo_nxt    = 1'b0;
    case (state)
      IDLE: if (ready_in && (~empty_in != '0)) state_nxt = ARB;
      ARB: begin
        if (found) begin
          sel_nxt    = found_idx;
          credit_nxt = qos_mode ? eff_w[found_idx] : WEIGHT_W'(1);
          wdog_nxt   = '0;
          state_nxt  = READ;
        end else begin
          state_nxt  = IDLE;
        end
      end
      READ: begin
        if (rd_done) begin
          credit_nxt = credit - 1'b1;
          state_nxt  = DONE;
        end else if (wdog == WDOG_W'(TIMEOUT_CYC-1)) begin
          tmo_nxt    = 1'b1;
          ptr_nxt    = inc_mod(rd_sel);
          state_nxt  = IDLE;
        end else begin
          wdog_nxt   = wdog + 1'b1;
        end
      end
      DONE: begin
        // Remaining credit keeps the same source for another packet after a 1-cycle bubble.
        if (credit != '0 && !empty_in[rd_sel] && ready_in) begin
          wdog_nxt  = '0;
          state_nxt = READ;
        end else begin
          ptr_nxt   = inc_mod(rd_sel);
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge internal_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      credit      <= '0;
      wdog        <= '0;
      rd_sel      <= '0;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      credit      <= credit_nxt;
      wdog        <= wdog_nxt;
      rd_sel      <= sel_nxt;
      rd_en       <= (state_nxt == READ);
      busy        <= (state_nxt != IDLE);
      timeout_err <= tmo_nxt;
    end
  end

endmodule
